switch_allocator: RTL and testbench

- Wormhole switch allocator for the router's 5x5 crossbar.
- Arbitrates input-port requests for output ports with a per-output round-robin arbiter.
- Locks each granted output to its winning input until the packet's tail flit transfers.
- Drives the crossbar select lines and per-input flit grants.

---
 rtl/switch_allocator.sv | 112 +++++++++++
 tb/tb_switch_allocator.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output round-robin arbitration with packet locking
// from head flit to tail flit, driving the crossbar selects and per-input flit grants.
module switch_allocator #(
    parameter int N_IN   = 5,
    parameter int N_OUT  = 5,
    parameter int DEST_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_IN-1:0]          req_valid,
    input  logic [N_IN*DEST_W-1:0]   req_dest,
    input  logic [N_IN-1:0]          req_tail,
    input  logic [N_OUT-1:0]         out_ready,
    output logic [N_IN-1:0]          grant,
    output logic [N_OUT*DEST_W-1:0]  xbar_sel,
    output logic [N_OUT-1:0]         xbar_valid,
    output logic                     dest_err
);

    logic [N_OUT-1:0]  r_lock;
    logic [DEST_W-1:0] r_owner [N_OUT];
    logic [DEST_W-1:0] r_ptr   [N_OUT];
    logic              r_dest_err;

    logic [N_IN-1:0]   w_owns;
    logic [N_OUT-1:0]  w_xfer;
    logic [N_OUT-1:0]  w_release;
    logic [N_OUT-1:0]  w_found;
    logic [DEST_W-1:0] w_winner  [N_OUT];
    logic [DEST_W-1:0] w_ptr_nxt [N_OUT];
    logic              w_dest_bad;

    // Transfer path: purely from lock state plus the owner's current request.
    always_comb begin
        w_owns    = '0;
        w_xfer    = '0;
        w_release = '0;
        grant     = '0;
        xbar_sel  = '0;
        for (int o = 0; o < N_OUT; o++) begin
            if (r_lock[o]) begin
                xbar_sel[o*DEST_W +: DEST_W] = r_owner[o];
                for (int i = 0; i < N_IN; i++) begin
                    if (r_owner[o] == DEST_W'(i)) begin
                        w_owns[i] = 1'b1;
                        if (req_valid[i] && out_ready[o] &&
                            req_dest[i*DEST_W +: DEST_W] == DEST_W'(o)) begin
                            w_xfer[o]    = 1'b1;
                            grant[i]     = 1'b1;
                            w_release[o] = req_tail[i];
                        end
                    end
                end
            end
        end
        xbar_valid = w_xfer;
    end

    always_comb begin
        int idx;
        idx = 0;
        for (int o = 0; o < N_OUT; o++) begin
            w_found[o]   = 1'b0;
            w_winner[o]  = '0;
            w_ptr_nxt[o] = '0;
            for (int k = 0; k < N_IN; k++) begin
                idx = int'(r_ptr[o]) + k;
                if (idx >= N_IN) idx = idx - N_IN;
                if (!w_found[o] && req_valid[idx] && !w_owns[idx] &&
                    req_dest[idx*DEST_W +: DEST_W] == DEST_W'(o)) begin
                    w_found[o]   = 1'b1;
                    w_winner[o]  = DEST_W'(idx);
                    w_ptr_nxt[o] = (idx == N_IN - 1) ? '0 : DEST_W'(idx + 1);
                end
            end
        end
    end

    always_comb begin
        w_dest_bad = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (req_valid[i] && int'(req_dest[i*DEST_W +: DEST_W]) >= N_OUT) begin
                w_dest_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lock     <= '0;
            r_dest_err <= 1'b0;
            for (int o = 0; o < N_OUT; o++) begin
                r_owner[o] <= '0;
                r_ptr[o]   <= '0;
            end
        end else begin
            r_dest_err <= w_dest_bad;
            for (int o = 0; o < N_OUT; o++) begin
                if (r_lock[o]) begin
                    if (w_release[o]) r_lock[o] <= 1'b0;
                end else if (w_found[o]) begin
                    r_lock[o]  <= 1'b1;
                    r_owner[o] <= w_winner[o];
                    r_ptr[o]   <= w_ptr_nxt[o];
                end
            end
        end
    end

    assign dest_err = r_dest_err;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed-vector bench for switch_allocator: reset, round-robin, wormhole lock,
// backpressure, parallel permutation, invalid destination and mid-packet reset.
module tb_switch_allocator;

    localparam int N_IN   = 5;
    localparam int N_OUT  = 5;
    localparam int DEST_W = 3;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_IN-1:0]         req_valid;
    logic [N_IN*DEST_W-1:0]  req_dest;
    logic [N_IN-1:0]         req_tail;
    logic [N_OUT-1:0]        out_ready;
    logic [N_IN-1:0]         grant;
    logic [N_OUT*DEST_W-1:0] xbar_sel;
    logic [N_OUT-1:0]        xbar_valid;
    logic                    dest_err;

    int n_checks = 0;
    int n_errors = 0;

    switch_allocator #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .DEST_W (DEST_W)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_dest   (req_dest),
        .req_tail   (req_tail),
        .out_ready  (out_ready),
        .grant      (grant),
        .xbar_sel   (xbar_sel),
        .xbar_valid (xbar_valid),
        .dest_err   (dest_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after the edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input int d, input logic t);
        req_valid[i]              = 1'b1;
        req_dest[i*DEST_W +: DEST_W] = DEST_W'(d);
        req_tail[i]               = t;
    endtask

    function automatic logic [DEST_W-1:0] sel(input int o);
        return xbar_sel[o*DEST_W +: DEST_W];
    endfunction

    int exp_rr [6] = '{0, 1, 3, 0, 1, 3};
    logic [N_OUT*DEST_W-1:0] exp_sel;

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_dest  = '0;
        req_tail  = '1;
        out_ready = '1;
        set_req(1, 6, 1'b1);

        // Reset with requests (including an invalid one) active
        tick();
        tick();
        settle();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_xvalid", 32'(xbar_valid), 32'h0);
        check("rst_xsel", 32'(xbar_sel), 32'h0);
        check("rst_dest_err", 32'(dest_err), 32'h0);

        rst_n     = 1'b1;
        req_valid = '0;
        set_req(2, 4, 1'b1);
        settle();
        check("hdr_idle_grant", 32'(grant), 32'h0);
        tick();
        settle();
        check("hdr_grant", 32'(grant), 32'b00100);
        check("hdr_xsel4", 32'(sel(4)), 32'd2);
        check("hdr_xvalid", 32'(xbar_valid), 32'b10000);
        tick();
        req_valid = '0;
        settle();
        check("hdr_released", 32'(grant), 32'h0);
        tick();

        // Round-robin on output 1 among inputs 0,1,3
        set_req(0, 1, 1'b1);
        set_req(1, 1, 1'b1);
        set_req(3, 1, 1'b1);
        for (int n = 0; n < 6; n++) begin
            settle();
            check("rr_idle", 32'(grant), 32'h0);
            tick();
            settle();
            check("rr_grant", 32'(grant), 32'(1 << exp_rr[n]));
            check("rr_xsel1", 32'(sel(1)), 32'(exp_rr[n]));
            tick();
        end
        req_valid = '0;
        tick();

        // Wormhole: 4-flit packet from input 0 to output 2, input 4 waiting
        set_req(0, 2, 1'b0);
        set_req(4, 2, 1'b1);
        settle();
        check("wh_idle", 32'(grant), 32'h0);
        tick();
        for (int f = 0; f < 4; f++) begin
            req_tail[0] = (f == 3);
            settle();
            check("wh_flit", 32'(grant), 32'b00001);
            check("wh_xsel2", 32'(sel(2)), 32'd0);
            tick();
        end
        req_valid[0] = 1'b0;
        settle();
        check("wh_realloc", 32'(grant), 32'h0);
        tick();
        settle();
        check("wh_in4_grant", 32'(grant), 32'b10000);
        check("wh_in4_xsel2", 32'(sel(2)), 32'd4);
        tick();
        req_valid = '0;
        tick();

        // Backpressure: input 3 locked on output 0, input 1 tries to steal
        set_req(3, 0, 1'b0);
        tick();
        settle();
        check("bp_first", 32'(grant), 32'b01000);
        tick();
        set_req(1, 0, 1'b1);
        out_ready[0] = 1'b0;
        for (int s = 0; s < 3; s++) begin
            settle();
            check("bp_stall_grant", 32'(grant), 32'h0);
            check("bp_stall_xvalid", 32'(xbar_valid), 32'h0);
            check("bp_stall_owner", 32'(sel(0)), 32'd3);
            tick();
        end
        out_ready[0] = 1'b1;
        req_tail[3]  = 1'b1;
        settle();
        check("bp_resume", 32'(grant), 32'b01000);
        check("bp_resume_xvalid", 32'(xbar_valid), 32'b00001);
        tick();
        req_valid = '0;
        tick();

        // Parallel permutation: input i -> output 4-i
        exp_sel = '0;
        for (int i = 0; i < N_IN; i++) begin
            set_req(i, 4 - i, 1'b0);
            exp_sel[(4 - i)*DEST_W +: DEST_W] = DEST_W'(i);
        end
        settle();
        check("perm_idle", 32'(grant), 32'h0);
        tick();
        settle();
        check("perm_grant", 32'(grant), 32'b11111);
        check("perm_xvalid", 32'(xbar_valid), 32'b11111);
        check("perm_xsel", 32'(xbar_sel), 32'(exp_sel));
        req_tail = '1;
        tick();
        req_valid = '0;
        tick();

        // Invalid destination: one-cycle registered pulse, no lock
        set_req(1, 6, 1'b1);
        settle();
        check("derr_before", 32'(dest_err), 32'h0);
        tick();
        req_valid = '0;
        settle();
        check("derr_pulse", 32'(dest_err), 32'h1);
        check("derr_no_grant", 32'(grant), 32'h0);
        tick();
        settle();
        check("derr_cleared", 32'(dest_err), 32'h0);
        check("derr_no_lock", 32'(xbar_valid), 32'h0);

        // Mid-packet reset on output 3; ptr[3] would otherwise favour input 4
        set_req(1, 3, 1'b0);
        tick();
        set_req(4, 3, 1'b0);
        settle();
        check("mr_locked", 32'(grant), 32'b00010);
        rst_n = 1'b0;
        tick();
        settle();
        check("mr_grant", 32'(grant), 32'h0);
        check("mr_xsel", 32'(xbar_sel), 32'h0);
        rst_n = 1'b1;
        tick();
        settle();
        check("mr_ptr0_grant", 32'(grant), 32'b00010);
        check("mr_ptr0_xsel3", 32'(sel(3)), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
